seven_seg_scanner: RTL and testbench

- Parametrised multi-digit, time-multiplexed seven-segment display driver; next generation of the team's single-digit truth-table decoder.
- Drives NUM_DIGITS common-anode/cathode digits from one packed nibble bus, with:
  - selectable hex/BCD decoding
  - leading-zero blanking
  - per-digit decimal points
  - anti-ghosting blank window
  - tear-free frame-synchronous value update
- Sits between the arithmetic datapath (adder/counter results) and the board's seg/an pins.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/seven_seg_scanner.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment patterns (active-high, a=bit0) and pin polarity helper
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Maps active-high "lit" bits to pin levels; callers truncate to their width.
  function automatic logic [7:0] to_pins(input logic [7:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - nibble to active-high seven-segment pattern
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = hex_mode_i ? SEG_A : SEG_BLANK;
      4'hB:    seg_o = hex_mode_i ? SEG_B : SEG_BLANK;
      4'hC:    seg_o = hex_mode_i ? SEG_C : SEG_BLANK;
      4'hD:    seg_o = hex_mode_i ? SEG_D : SEG_BLANK;
      4'hE:    seg_o = hex_mode_i ? SEG_E : SEG_BLANK;
      default: seg_o = hex_mode_i ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed multi-digit seven-segment driver
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2000,
  parameter int HEX_MODE       = 1,
  parameter int BLANK_LEADING  = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = 7'(to_pins(8'h00, SEG_ACTIVE_LOW != 0));
  localparam logic                  DP_OFF  = 1'(to_pins(8'h00, SEG_ACTIVE_LOW != 0));
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = NUM_DIGITS'(to_pins(8'h00, AN_ACTIVE_LOW != 0));

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    pre_wrap, frame_wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    hi_nonzero;
  logic                    lead_blank;
  logic                    an_on;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [6:0]              dec_seg, seg_lit;

  always_comb begin
    pre_wrap     = enable && (pre_q == PRE_LAST);
    frame_wrap   = pre_wrap && (idx_q == IDX_LAST);
    pre_d        = pre_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    tick_d       = frame_wrap;

    if (enable) begin
      pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    // Display only changes between frames so a multi-digit value never tears.
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end
  end

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    hi_nonzero = 1'b0;
    an_lit     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        an_lit[i] = 1'b1;
      end
      if ((IDX_W'(i) >= idx_q) && (disp_val_q[4*i +: 4] != 4'h0)) begin
        hi_nonzero = 1'b1;
      end
    end
    lead_blank = (BLANK_LEADING != 0) && (idx_q != '0) && !hi_nonzero;
    seg_lit    = lead_blank ? SEG_BLANK : dec_seg;
    an_on      = enable && (pre_q >= BLANK_END);
    seg_d      = 7'(to_pins({1'b0, seg_lit}, SEG_ACTIVE_LOW != 0));
    dp_d       = 1'(to_pins({7'b0, cur_dp}, SEG_ACTIVE_LOW != 0));
    an_d       = NUM_DIGITS'(to_pins(8'(an_on ? an_lit : '0), AN_ACTIVE_LOW != 0));
  end

  seven_seg_decoder u_decoder (
    .nibble_i   (cur_nib),
    .hex_mode_i (HEX_MODE != 0),
    .seg_o      (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      tick_q       <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg, seg_h0, seg_bl;
  logic        dp, dp_h0, dp_bl;
  logic [3:0]  an, an_h0, an_bl;
  logic        tick, tick_h0, tick_bl;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                      .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_tick(tick));

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0),
                      .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut_h0 (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
    .seg(seg_h0), .dp(dp_h0), .an(an_h0), .frame_tick(tick_h0));

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                      .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut_bl (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
    .seg(seg_bl), .dp(dp_bl), .an(an_bl), .frame_tick(tick_bl));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      step();
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    step();
    step();
    checks++;
    if ({an, seg, dp, tick} !== 13'b1111_1111111_1_0) begin
      errors++; $display("FAIL reset_main got %b required %b", {an, seg, dp, tick}, 13'b1111_1111111_1_0);
    end
    checks++;
    if ({an_h0, seg_h0, dp_h0, tick_h0} !== 13'b1111_1111111_1_0) begin
      errors++; $display("FAIL reset_hex0 got %b required %b", {an_h0, seg_h0, dp_h0, tick_h0}, 13'b1111_1111111_1_0);
    end
    checks++;
    if ({an_bl, seg_bl, dp_bl, tick_bl} !== 13'b1111_1111111_1_0) begin
      errors++; $display("FAIL reset_blank got %b required %b", {an_bl, seg_bl, dp_bl, tick_bl}, 13'b1111_1111111_1_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4] = '{7'b1000000, 7'b0000000, 7'b0100100, 7'b1111001};
    logic [3:0] exp_dp = 4'b1010;
    logic [3:0] exp_an;
    bit ok;
    int d, p;
    do_load(16'h1280, 4'b0101);
    enable = 1'b1;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_tick got none required pulse"); end
    for (int s = 1; s <= 16; s++) begin
      step();
      d = (s - 1) / 4;
      p = (s - 1) % 4;
      exp_an = (p == 0) ? 4'b1111 : ~(4'b0001 << d);
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL scan_an s=%0d got %b required %b", s, an, exp_an); end
      checks++;
      if (tick !== (s == 16)) begin errors++; $display("FAIL scan_tick s=%0d got %b required %b", s, tick, s == 16); end
      if (p != 0) begin
        checks++;
        if (seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg s=%0d got %b required %b", s, seg, exp_seg[d]); end
        checks++;
        if (dp !== exp_dp[d]) begin errors++; $display("FAIL scan_dp s=%0d got %b required %b", s, dp, exp_dp[d]); end
        checks++;
        if (seg_h0 !== exp_seg[d]) begin errors++; $display("FAIL scan_seg_hex0 s=%0d got %b required %b", s, seg_h0, exp_seg[d]); end
        checks++;
        if (seg_bl !== exp_seg[d]) begin errors++; $display("FAIL scan_seg_blank s=%0d got %b required %b", s, seg_bl, exp_seg[d]); end
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
    bit ok;
    int d;
    do_load(16'hABCD, 4'b0000);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hex_tick got none required pulse"); end
    for (int s = 1; s <= 16; s++) begin
      step();
      d = (s - 1) / 4;
      if ((s - 1) % 4 != 0) begin
        checks++;
        if (seg !== exp_seg[d]) begin errors++; $display("FAIL hex_seg s=%0d got %b required %b", s, seg, exp_seg[d]); end
        checks++;
        if (seg_h0 !== 7'b1111111) begin errors++; $display("FAIL hex0_seg s=%0d got %b required %b", s, seg_h0, 7'b1111111); end
      end
    end
  endtask

  task automatic test_blank_leading();
    logic [15:0] vals [3]    = '{16'h0005, 16'h0105, 16'h0000};
    logic [3:0]  dps  [3]    = '{4'b1000, 4'b0000, 4'b0000};
    logic [6:0]  exp_bl [3][4] = '{'{7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111},
                                   '{7'b0010010, 7'b1000000, 7'b1111001, 7'b1111111},
                                   '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}};
    logic [3:0]  exp_dp [3]  = '{4'b0111, 4'b1111, 4'b1111};
    logic [6:0]  exp_main [4] = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000};
    bit ok;
    int d;
    for (int v = 0; v < 3; v++) begin
      do_load(vals[v], dps[v]);
      wait_tick(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL blank_tick v=%0d got none required pulse", v); end
      for (int s = 1; s <= 16; s++) begin
        step();
        d = (s - 1) / 4;
        if ((s - 1) % 4 != 0) begin
          checks++;
          if (seg_bl !== exp_bl[v][d]) begin errors++; $display("FAIL blank_seg v=%0d s=%0d got %b required %b", v, s, seg_bl, exp_bl[v][d]); end
          checks++;
          if (dp_bl !== exp_dp[v][d]) begin errors++; $display("FAIL blank_dp v=%0d s=%0d got %b required %b", v, s, dp_bl, exp_dp[v][d]); end
          if (v == 0) begin
            checks++;
            if (seg !== exp_main[d]) begin errors++; $display("FAIL noblank_seg s=%0d got %b required %b", s, seg, exp_main[d]); end
          end
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    bit ok;
    int d, p;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_tick got none required pulse"); end
    for (int s = 1; s <= 32; s++) begin
      step();
      d = ((s - 1) / 4) % 4;
      p = (s - 1) % 4;
      exp_an  = (p == 0) ? 4'b1111 : ~(4'b0001 << d);
      exp_seg = (s <= 16) ? 7'b1000000 : 7'b1111001;
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL mid_an s=%0d got %b required %b", s, an, exp_an); end
      checks++;
      if (tick !== (s == 16 || s == 32)) begin errors++; $display("FAIL mid_tick s=%0d got %b required %b", s, tick, s == 16 || s == 32); end
      if (p != 0) begin
        checks++;
        if (seg !== exp_seg) begin errors++; $display("FAIL mid_seg s=%0d got %b required %b", s, seg, exp_seg); end
      end
      if (s == 5) begin value = 16'h1111; dp_in = 4'b0000; load = 1'b1; end
      else load = 1'b0;
    end
  endtask

  task automatic test_wrap_load();
    logic [6:0] exp_seg;
    bit ok;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_tick got none required pulse"); end
    for (int s = 1; s <= 32; s++) begin
      step();
      exp_seg = (s <= 16) ? 7'b1111001 : 7'b0110000;
      if ((s - 1) % 4 != 0) begin
        checks++;
        if (seg !== exp_seg) begin errors++; $display("FAIL wrap_seg s=%0d got %b required %b", s, seg, exp_seg); end
      end
      checks++;
      if (tick !== (s == 16 || s == 32)) begin errors++; $display("FAIL wrap_tick s=%0d got %b required %b", s, tick, s == 16 || s == 32); end
      if (s == 3) begin value = 16'h2222; load = 1'b1; end
      else if (s == 15) begin value = 16'h3333; load = 1'b1; end
      else load = 1'b0;
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_an [4] = '{4'b1101, 4'b1101, 4'b1111, 4'b1011};
    bit ok;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL en_tick got none required pulse"); end
    for (int s = 1; s <= 6; s++) step();
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (an !== 4'b1111) begin errors++; $display("FAIL en_off_an k=%0d got %b required %b", k, an, 4'b1111); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL en_off_tick k=%0d got %b required 0", k, tick); end
      if (k == 2) begin value = 16'h4444; load = 1'b1; end
      else load = 1'b0;
    end
    enable = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      step();
      if (r <= 4) begin
        checks++;
        if (an !== exp_an[r-1]) begin errors++; $display("FAIL en_resume_an r=%0d got %b required %b", r, an, exp_an[r-1]); end
      end
      checks++;
      if (tick !== (r == 10)) begin errors++; $display("FAIL en_resume_tick r=%0d got %b required %b", r, tick, r == 10); end
      if (r == 12) begin
        checks++;
        if ({an, seg} !== {4'b1110, 7'b0011001}) begin
          errors++; $display("FAIL en_load_seg got %b required %b", {an, seg}, {4'b1110, 7'b0011001});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_tick got none required pulse"); end
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 3) begin value = 16'h5555; dp_in = 4'b1111; load = 1'b1; end
      else load = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({an, seg, dp, tick} !== 13'b1111_1111111_1_0) begin
      errors++; $display("FAIL rstmid_out got %b required %b", {an, seg, dp, tick}, 13'b1111_1111111_1_0);
    end
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_tick2 got none required pulse"); end
    for (int s = 1; s <= 16; s++) begin
      step();
      if ((s - 1) % 4 != 0) begin
        checks++;
        if ({seg, dp} !== {7'b1000000, 1'b1}) begin
          errors++; $display("FAIL rstmid_seg s=%0d got %b required %b", s, {seg, dp}, {7'b1000000, 1'b1});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_blank_leading();
    test_midframe();
    test_wrap_load();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
